// File: rtl/bus_slave_resp_mux_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_resp_mux_pkg
//   Shared constants and types for the slave read-response multiplexer.
//   - ENABLE_ / DISABLE_ : active-low bus strobe levels used by the fabric.
//   - BUS_SLAVE_TIMEOUT_CYC : default response timeout in clock cycles.
//   - BusErrData : word returned to the master when an access is aborted.
//   - tmr_state_e : state encoding of the response timeout FSM.
// -----------------------------------------------------------------------------
package bus_slave_resp_mux_pkg;

    // Active-low strobe levels of the shared bus
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Word width of the shared data bus
    localparam int WORD_DATA_W = 32;

    // Default cycles a slave may stall before the access is forcibly ended
    localparam int BUS_SLAVE_TIMEOUT_CYC = 255;

    // Data pattern returned on a timed-out access
    localparam logic [31:0] BusErrData = 32'hDEAD_BEEF;

    // Response timeout FSM states
    typedef enum logic [1:0] {
        TMR_IDLE  = 2'b00,  // no chip select active
        TMR_WAIT  = 2'b01,  // access pending, counting stalled cycles
        TMR_ABORT = 2'b10,  // one-cycle forced error completion
        TMR_HOLD  = 2'b11   // wait for chip selects to drop after abort
    } tmr_state_e;

endpackage : bus_slave_resp_mux_pkg

// File: rtl/bus_resp_timer.sv
// -----------------------------------------------------------------------------
// bus_resp_timer
//   Per-transaction response timeout for bus_slave_resp_mux. Counts cycles in
//   which the selected slave keeps its ready deasserted and, once the count
//   reaches TIMEOUT_CYC, signals a one-cycle abort followed by a hold phase
//   that lasts until every chip select is released.
//
//   Ports:
//     clk       in   system clock
//     reset_    in   synchronous active-low reset
//     any_cs    in   at least one slave chip select asserted this cycle
//     sel_rdy_  in   ready (active low) of the currently selected slave
//     sel_chg   in   selected slave index differs from the previous cycle
//     abort     out  registered: current cycle is the forced error completion
//     hold      out  registered: post-abort hold, slave ready must be ignored
// -----------------------------------------------------------------------------
module bus_resp_timer
    import bus_slave_resp_mux_pkg::*;
#(
    parameter int TIMEOUT_CYC = BUS_SLAVE_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset_,
    input  logic any_cs,
    input  logic sel_rdy_,
    input  logic sel_chg,
    output logic abort,
    output logic hold
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             hold_q, hold_d;
    logic [CNT_W-1:0] base_s;
    logic [CNT_W-1:0] inc_s;

    // Next-state, counter and output decode for the timeout FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A new slave index starts a fresh count, this cycle being its first
        if (sel_chg) begin
            base_s = CNT_ZERO;
        end else begin
            base_s = cnt_q;
        end
        // Saturating increment; the counter never wraps
        if (base_s >= CNT_MAX) begin
            inc_s = CNT_MAX;
        end else begin
            inc_s = base_s + CNT_ONE;
        end

        case (state_q)
            // IDLE and WAIT share one decode: IDLE simply has a zero count,
            // so the cycle in which cs_ first asserts is already counted.
            TMR_IDLE, TMR_WAIT: begin
                if (!any_cs) begin
                    state_d = TMR_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (sel_rdy_ == ENABLE_) begin
                    // Completed; a still-asserted cs_ is a back-to-back access
                    state_d = TMR_WAIT;
                    cnt_d   = CNT_ZERO;
                end else if (inc_s >= CNT_MAX) begin
                    state_d = TMR_ABORT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = TMR_WAIT;
                    cnt_d   = inc_s;
                end
            end
            TMR_ABORT: begin
                state_d = TMR_HOLD;
                cnt_d   = CNT_ZERO;
            end
            TMR_HOLD: begin
                if (any_cs) begin
                    state_d = TMR_HOLD;
                end else begin
                    state_d = TMR_IDLE;
                end
                cnt_d = CNT_ZERO;
            end
            default: begin
                state_d = TMR_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        abort_d = (state_d == TMR_ABORT);
        hold_d  = (state_d == TMR_HOLD);
    end

    // State, counter and registered output flops with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= TMR_IDLE;
            cnt_q   <= CNT_ZERO;
            abort_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            hold_q  <= hold_d;
        end
    end

    assign abort = abort_q;
    assign hold  = hold_q;

endmodule : bus_resp_timer

// File: rtl/bus_slave_resp_mux.sv
// -----------------------------------------------------------------------------
// bus_slave_resp_mux
//   Slave-to-master read-response multiplexer. The lowest-index slave with its
//   chip select asserted drives read data and ready back to the master in the
//   same cycle. A sticky flag records any cycle with overlapping chip selects.
//
//   Optional feature, macro BUS_SLAVE_RESP_TIMEOUT_EN:
//     defined     - bus_resp_timer terminates an access whose slave stalls for
//                   TIMEOUT_CYC cycles with a one-cycle ERR_DATA/m_err response.
//     undefined   - pure priority mux plus multi_sel_err; m_err tied low.
//
//   Ports:
//     clk            in   system clock
//     reset_         in   synchronous active-low reset (also forces outputs)
//     s_cs_          in   per-slave chip select, active low
//     s_rd_data      in   packed slave read data, slave i at [i*DATA_W +: DATA_W]
//     s_rdy_         in   per-slave ready, active low
//     err_clr        in   clears multi_sel_err (a coincident set wins)
//     m_rd_data      out  read data to master
//     m_rdy_         out  ready to master, active low
//     m_err          out  one-cycle pulse on timeout termination
//     m_sel          out  granted slave index, 0 when none
//     multi_sel_err  out  sticky overlapping chip select flag
// -----------------------------------------------------------------------------
module bus_slave_resp_mux
    import bus_slave_resp_mux_pkg::*;
#(
    parameter int                NUM_SLAVES  = 8,
    parameter int                DATA_W      = WORD_DATA_W,
    parameter int                TIMEOUT_CYC = BUS_SLAVE_TIMEOUT_CYC,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(BusErrData)
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic [NUM_SLAVES-1:0]        s_cs_,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
    input  logic [NUM_SLAVES-1:0]        s_rdy_,
    input  logic                         err_clr,
    output logic [DATA_W-1:0]            m_rd_data,
    output logic                         m_rdy_,
    output logic                         m_err,
    output logic [$clog2(NUM_SLAVES)-1:0] m_sel,
    output logic                         multi_sel_err
);

    localparam int SEL_W = $clog2(NUM_SLAVES);

    // Reject unsupported configurations at elaboration time
    if ((NUM_SLAVES < 2) || (NUM_SLAVES > 16) || (TIMEOUT_CYC < 1) ||
        ($bits(ERR_DATA) != DATA_W)) begin : g_param_check
        $error("bus_slave_resp_mux: unsupported parameter set");
    end

    // Lowest asserted (active-low) chip select wins; 0 when none asserted
    function automatic logic [SEL_W-1:0] prio_enc(input logic [NUM_SLAVES-1:0] cs_n);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (cs_n[i] == ENABLE_) begin
                idx = SEL_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when two or more chip selects are asserted together
    function automatic logic multi_hot(input logic [NUM_SLAVES-1:0] cs_n);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cs_n[i] == ENABLE_) begin
                n = n + 5'd1;
            end else begin
                n = n;
            end
        end
        return (n >= 5'd2);
    endfunction

    logic [SEL_W-1:0]  sel_s;
    logic              any_cs_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_rdy_s;
    logic              abort_s;
    logic              hold_s;
    logic              multi_sel_err_q, multi_sel_err_d;

    // Priority selection and slave data/ready steering
    always_comb begin
        sel_s      = prio_enc(s_cs_);
        any_cs_s   = ~(&s_cs_);
        sel_data_s = {DATA_W{1'b0}};
        sel_rdy_s  = DISABLE_;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (SEL_W'(i) == sel_s) begin
                sel_data_s = s_rd_data[i*DATA_W +: DATA_W];
                sel_rdy_s  = s_rdy_[i];
            end else begin
                sel_data_s = sel_data_s;
                sel_rdy_s  = sel_rdy_s;
            end
        end
    end

`ifdef BUS_SLAVE_RESP_TIMEOUT_EN
    logic [SEL_W-1:0] sel_prev_q, sel_prev_d;
    logic             any_cs_prev_q, any_cs_prev_d;
    logic             sel_chg_s;

    // Detect a switch to a different slave while an access is in flight
    always_comb begin
        sel_prev_d    = sel_s;
        any_cs_prev_d = any_cs_s;
        if (any_cs_s && any_cs_prev_q && (sel_s != sel_prev_q)) begin
            sel_chg_s = 1'b1;
        end else begin
            sel_chg_s = 1'b0;
        end
    end

    // Previous-cycle selection history with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_) begin
            sel_prev_q    <= {SEL_W{1'b0}};
            any_cs_prev_q <= 1'b0;
        end else begin
            sel_prev_q    <= sel_prev_d;
            any_cs_prev_q <= any_cs_prev_d;
        end
    end

    bus_resp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .reset_   (reset_),
        .any_cs   (any_cs_s),
        .sel_rdy_ (sel_rdy_s),
        .sel_chg  (sel_chg_s),
        .abort    (abort_s),
        .hold     (hold_s)
    );
`else
    assign abort_s = 1'b0;
    assign hold_s  = 1'b0;
`endif

    // Sticky overlap flag: a new overlap takes priority over err_clr
    always_comb begin
        if (multi_hot(s_cs_)) begin
            multi_sel_err_d = 1'b1;
        end else if (err_clr) begin
            multi_sel_err_d = 1'b0;
        end else begin
            multi_sel_err_d = multi_sel_err_q;
        end
    end

    // Overlap flag register with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_) begin
            multi_sel_err_q <= 1'b0;
        end else begin
            multi_sel_err_q <= multi_sel_err_d;
        end
    end

    // Master-side response; reset_ low overrides everything, abort beats slave
    always_comb begin
        m_rd_data     = {DATA_W{1'b0}};
        m_rdy_        = DISABLE_;
        m_err         = 1'b0;
        m_sel         = {SEL_W{1'b0}};
        multi_sel_err = 1'b0;
        if (!reset_) begin
            m_rd_data = {DATA_W{1'b0}};
        end else begin
            multi_sel_err = multi_sel_err_q;
            m_sel         = sel_s;
            if (abort_s) begin
                m_rd_data = ERR_DATA;
                m_rdy_    = ENABLE_;
                m_err     = 1'b1;
            end else if (hold_s) begin
                m_rd_data = {DATA_W{1'b0}};
            end else if (any_cs_s) begin
                m_rd_data = sel_data_s;
                m_rdy_    = sel_rdy_s;
            end else begin
                m_rd_data = {DATA_W{1'b0}};
            end
        end
    end

endmodule : bus_slave_resp_mux

// File: tb/tb_bus_slave_resp_mux.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_resp_mux
//   Directed self-checking bench for bus_slave_resp_mux with 8 slaves, 32-bit
//   data and a 4-cycle timeout. Timeout scenarios run when
//   BUS_SLAVE_RESP_TIMEOUT_EN is defined; otherwise the no-timeout behaviour
//   of the plain mux is exercised. Inputs change 1 time unit after the rising
//   edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_slave_resp_mux;

    logic         clk;
    logic         reset_;
    logic [7:0]   s_cs_;
    logic [255:0] s_rd_data;
    logic [7:0]   s_rdy_;
    logic         err_clr;
    logic [31:0]  m_rd_data;
    logic         m_rdy_;
    logic         m_err;
    logic [2:0]   m_sel;
    logic         multi_sel_err;

    int total;
    int bad;

    bus_slave_resp_mux #(
        .NUM_SLAVES  (8),
        .DATA_W      (32),
        .TIMEOUT_CYC (4),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .s_cs_         (s_cs_),
        .s_rd_data     (s_rd_data),
        .s_rdy_        (s_rdy_),
        .err_clr       (err_clr),
        .m_rd_data     (m_rd_data),
        .m_rdy_        (m_rdy_),
        .m_err         (m_err),
        .m_sel         (m_sel),
        .multi_sel_err (multi_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle_start;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic go_idle;
        for (int k = 0; k < 2; k++) begin
            cycle_start;
            s_cs_   = 8'hFF;
            s_rdy_  = 8'hFF;
            err_clr = 1'b0;
            sample;
        end
    endtask

    task automatic test_reset;
        reset_ = 1'b0;
        s_cs_  = 8'b1111_0011;
        s_rdy_ = 8'b1111_0011;
        s_rd_data[2*32 +: 32] = 32'hAAAA_5555;
        for (int k = 0; k < 3; k++) cycle_start;
        sample;
        total++; if (m_rd_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=00000000", m_rd_data); end
        total++; if (m_rdy_ !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b want=1", m_rdy_); end
        total++; if (m_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", m_err); end
        total++; if (m_sel !== 3'd0) begin bad++; $display("FAIL rst_sel got=%0d want=0", m_sel); end
        total++; if (multi_sel_err !== 1'b0) begin bad++; $display("FAIL rst_multi got=%b want=0", multi_sel_err); end
        cycle_start;
        reset_ = 1'b1;
        s_cs_  = 8'hFF;
        s_rdy_ = 8'hFF;
        sample;
        total++; if (m_rdy_ !== 1'b1) begin bad++; $display("FAIL idle_rdy got=%b want=1", m_rdy_); end
        total++; if (m_rd_data !== 32'h0) begin bad++; $display("FAIL idle_data got=%h want=00000000", m_rd_data); end
        total++; if (multi_sel_err !== 1'b0) begin bad++; $display("FAIL idle_multi got=%b want=0", multi_sel_err); end
        go_idle;
    endtask

    task automatic test_single_read;
        logic exp_rdy;
        s_rd_data[2*32 +: 32] = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            cycle_start;
            s_cs_  = 8'b1111_1011;
            s_rdy_ = (c == 3) ? 8'b1111_1011 : 8'hFF;
            sample;
            exp_rdy = (c == 3) ? 1'b0 : 1'b1;
            total++; if (m_sel !== 3'd2) begin bad++; $display("FAIL rd_sel c=%0d got=%0d want=2", c, m_sel); end
            total++; if (m_rd_data !== 32'h1234_5678) begin bad++; $display("FAIL rd_data c=%0d got=%h want=12345678", c, m_rd_data); end
            total++; if (m_rdy_ !== exp_rdy) begin bad++; $display("FAIL rd_rdy c=%0d got=%b want=%b", c, m_rdy_, exp_rdy); end
            total++; if (m_err !== 1'b0) begin bad++; $display("FAIL rd_err c=%0d got=%b want=0", c, m_err); end
        end
        go_idle;
    endtask

    task automatic test_priority;
        logic [31:0] exp_data;
        for (int j = 0; j < 8; j++) s_rd_data[j*32 +: 32] = 32'h5000_0000 + (32'h0000_0111 * j);
        for (int i = 0; i < 8; i++) begin
            cycle_start;
            s_cs_  = ~(8'd1 << i);
            s_rdy_ = 8'h00;
            sample;
            exp_data = 32'h5000_0000 + (32'h0000_0111 * i);
            total++; if (m_sel !== 3'(i)) begin bad++; $display("FAIL prio_sel i=%0d got=%0d want=%0d", i, m_sel, i); end
            total++; if (m_rd_data !== exp_data) begin bad++; $display("FAIL prio_data i=%0d got=%h want=%h", i, m_rd_data, exp_data); end
            total++; if (m_rdy_ !== 1'b0) begin bad++; $display("FAIL prio_rdy i=%0d got=%b want=0", i, m_rdy_); end
            cycle_start;
            s_cs_  = 8'hFF;
            s_rdy_ = 8'hFF;
            sample;
        end
        total++; if (multi_sel_err !== 1'b0) begin bad++; $display("FAIL prio_multi got=%b want=0", multi_sel_err); end
        go_idle;
    endtask

    task automatic test_multi_sel;
        s_rd_data[1*32 +: 32] = 32'h1111_AAAA;
        s_rd_data[3*32 +: 32] = 32'h3333_BBBB;
        cycle_start;
        s_cs_  = 8'b1111_0101;
        s_rdy_ = 8'b1111_0101;
        sample;
        total++; if (m_sel !== 3'd1) begin bad++; $display("FAIL ms_sel got=%0d want=1", m_sel); end
        total++; if (m_rd_data !== 32'h1111_AAAA) begin bad++; $display("FAIL ms_data got=%h want=1111aaaa", m_rd_data); end
        total++; if (multi_sel_err !== 1'b0) begin bad++; $display("FAIL ms_same_cycle got=%b want=0", multi_sel_err); end
        cycle_start;
        s_cs_  = 8'hFF;
        s_rdy_ = 8'hFF;
        sample;
        total++; if (multi_sel_err !== 1'b1) begin bad++; $display("FAIL ms_set got=%b want=1", multi_sel_err); end
        cycle_start;
        sample;
        total++; if (multi_sel_err !== 1'b1) begin bad++; $display("FAIL ms_sticky got=%b want=1", multi_sel_err); end
        cycle_start;
        err_clr = 1'b1;
        sample;
        total++; if (multi_sel_err !== 1'b1) begin bad++; $display("FAIL ms_clr_cycle got=%b want=1", multi_sel_err); end
        cycle_start;
        err_clr = 1'b0;
        sample;
        total++; if (multi_sel_err !== 1'b0) begin bad++; $display("FAIL ms_cleared got=%b want=0", multi_sel_err); end
        // Overlap and clear in the same cycle: the overlap must win
        cycle_start;
        s_cs_   = 8'b0111_1110;
        err_clr = 1'b1;
        sample;
        cycle_start;
        s_cs_   = 8'hFF;
        err_clr = 1'b0;
        sample;
        total++; if (multi_sel_err !== 1'b1) begin bad++; $display("FAIL ms_set_wins got=%b want=1", multi_sel_err); end
        cycle_start;
        err_clr = 1'b1;
        sample;
        cycle_start;
        err_clr = 1'b0;
        sample;
        total++; if (multi_sel_err !== 1'b0) begin bad++; $display("FAIL ms_reclear got=%b want=0", multi_sel_err); end
        go_idle;
    endtask

`ifdef BUS_SLAVE_RESP_TIMEOUT_EN
    task automatic test_timeout;
        logic        exp_rdy;
        logic        exp_err;
        logic [31:0] exp_data;
        s_rd_data[0 +: 32] = 32'hCAFE_0000;
        for (int c = 0; c < 10; c++) begin
            cycle_start;
            s_cs_  = (c == 8) ? 8'hFF : 8'b1111_1110;
            s_rdy_ = (c >= 4) ? 8'b1111_1110 : 8'hFF;
            sample;
            exp_rdy  = ((c == 4) || (c == 9)) ? 1'b0 : 1'b1;
            exp_err  = (c == 4);
            exp_data = (c == 4) ? 32'hDEAD_BEEF :
                       ((c < 4) || (c == 9)) ? 32'hCAFE_0000 : 32'h0;
            total++; if (m_rdy_ !== exp_rdy) begin bad++; $display("FAIL to_rdy c=%0d got=%b want=%b", c, m_rdy_, exp_rdy); end
            total++; if (m_err !== exp_err) begin bad++; $display("FAIL to_err c=%0d got=%b want=%b", c, m_err, exp_err); end
            total++; if (m_rd_data !== exp_data) begin bad++; $display("FAIL to_data c=%0d got=%h want=%h", c, m_rd_data, exp_data); end
        end
        go_idle;
    endtask

    task automatic test_back_to_back;
        logic exp_rdy;
        s_rd_data[5*32 +: 32] = 32'h5555_0005;
        for (int c = 0; c < 8; c++) begin
            cycle_start;
            s_cs_  = 8'b1101_1111;
            s_rdy_ = ((c == 3) || (c == 7)) ? 8'b1101_1111 : 8'hFF;
            sample;
            exp_rdy = ((c == 3) || (c == 7)) ? 1'b0 : 1'b1;
            total++; if (m_rdy_ !== exp_rdy) begin bad++; $display("FAIL b2b_rdy c=%0d got=%b want=%b", c, m_rdy_, exp_rdy); end
            total++; if (m_err !== 1'b0) begin bad++; $display("FAIL b2b_err c=%0d got=%b want=0", c, m_err); end
            total++; if (m_rd_data !== 32'h5555_0005) begin bad++; $display("FAIL b2b_data c=%0d got=%h want=55550005", c, m_rd_data); end
        end
        go_idle;
    endtask

    task automatic test_sel_change;
        logic        exp_err;
        logic [2:0]  exp_sel;
        s_rd_data[2*32 +: 32] = 32'h2222_0002;
        s_rd_data[4*32 +: 32] = 32'h4444_0004;
        for (int c = 0; c < 8; c++) begin
            cycle_start;
            s_cs_  = (c < 3) ? 8'b1111_1011 : 8'b1110_1111;
            s_rdy_ = 8'hFF;
            sample;
            exp_err = (c == 7);
            exp_sel = (c < 3) ? 3'd2 : 3'd4;
            total++; if (m_err !== exp_err) begin bad++; $display("FAIL chg_err c=%0d got=%b want=%b", c, m_err, exp_err); end
            total++; if (m_sel !== exp_sel) begin bad++; $display("FAIL chg_sel c=%0d got=%0d want=%0d", c, m_sel, exp_sel); end
        end
        go_idle;
    endtask

    task automatic test_reset_mid;
        logic        exp_rdy;
        logic        exp_err;
        logic [31:0] exp_data;
        s_rd_data[0 +: 32] = 32'hCAFE_0000;
        for (int c = 0; c < 9; c++) begin
            cycle_start;
            reset_ = ((c == 2) || (c == 3)) ? 1'b0 : 1'b1;
            s_cs_  = 8'b1111_1110;
            s_rdy_ = 8'hFF;
            sample;
            exp_rdy  = (c == 8) ? 1'b0 : 1'b1;
            exp_err  = (c == 8);
            exp_data = (c == 8) ? 32'hDEAD_BEEF :
                       ((c == 2) || (c == 3)) ? 32'h0 : 32'hCAFE_0000;
            total++; if (m_err !== exp_err) begin bad++; $display("FAIL rm_err c=%0d got=%b want=%b", c, m_err, exp_err); end
            total++; if (m_rdy_ !== exp_rdy) begin bad++; $display("FAIL rm_rdy c=%0d got=%b want=%b", c, m_rdy_, exp_rdy); end
            total++; if (m_rd_data !== exp_data) begin bad++; $display("FAIL rm_data c=%0d got=%h want=%h", c, m_rd_data, exp_data); end
        end
        reset_ = 1'b1;
        go_idle;
    endtask
`else
    task automatic test_no_timeout;
        s_rd_data[6*32 +: 32] = 32'h6666_0006;
        for (int c = 0; c < 1000; c++) begin
            cycle_start;
            s_cs_  = 8'b1011_1111;
            s_rdy_ = 8'hFF;
            sample;
            total++; if (m_rdy_ !== 1'b1) begin bad++; $display("FAIL nt_rdy c=%0d got=%b want=1", c, m_rdy_); end
            total++; if (m_err !== 1'b0) begin bad++; $display("FAIL nt_err c=%0d got=%b want=0", c, m_err); end
        end
        total++; if (m_rd_data !== 32'h6666_0006) begin bad++; $display("FAIL nt_data got=%h want=66660006", m_rd_data); end
        total++; if (m_sel !== 3'd6) begin bad++; $display("FAIL nt_sel got=%0d want=6", m_sel); end
        go_idle;
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        reset_    = 1'b0;
        s_cs_     = 8'hFF;
        s_rdy_    = 8'hFF;
        s_rd_data = 256'h0;
        err_clr   = 1'b0;
        test_reset;
        test_single_read;
        test_priority;
        test_multi_sel;
`ifdef BUS_SLAVE_RESP_TIMEOUT_EN
        test_timeout;
        test_back_to_back;
        test_sel_change;
        test_reset_mid;
`else
        test_no_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_slave_resp_mux
